// File: rtl/det_calculator_param.sv
// Sequential 2x2 / 3x3 signed determinant engine: fetches the matrix row-major
// from an external memory, then accumulates one signed product term per cycle.
module det_calculator_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  localparam int OUT_W = 3*DATA_W+2
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic                     mode_i,
  input  logic [ADDR_W-1:0]        start_adress_i,
  input  logic [DATA_W-1:0]        data_in_i,
  output logic [ADDR_W-1:0]        adress_o,
  output logic signed [OUT_W-1:0]  out_put_o,
  output logic                     done_o,
  output logic                     busy_o
);

  localparam int PP_W = 2*DATA_W;
  localparam int TP_W = 3*DATA_W;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]               state_q, state_d;
  logic                     mode_q, mode_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [ADDR_W-1:0]        adr_q, adr_d;
  logic [3:0]               idx_q, idx_d;
  logic signed [DATA_W-1:0] elem_q [9];
  logic signed [PP_W-1:0]   pp_q, pp_d;
  logic signed [OUT_W-1:0]  acc_q, acc_d;
  logic signed [OUT_W-1:0]  out_q, out_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic signed [DATA_W-1:0] pa_s, pb_s, third_s;
  logic signed [PP_W-1:0]   pair_s;
  logic signed [TP_W-1:0]   triple_s;
  logic signed [OUT_W-1:0]  mag_s, term_s;
  logic                     neg_s;
  logic                     last_load_s, last_step_s;

  assign adress_o  = adr_q;
  assign out_put_o = out_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;

  assign last_load_s = (idx_q == (mode_q ? 4'd8 : 4'd3));
  // 3x3 terms are two-stage (pair product registered, third factor applied a
  // cycle later), so the 3x3 COMPUTE phase runs steps 0..6 with step 0 as fill.
  assign last_step_s = (idx_q == (mode_q ? 4'd6 : 4'd1));

  // Operand selection and signed term formation for the current COMPUTE step.
  always_comb begin
    pa_s    = elem_q[0];
    pb_s    = elem_q[3];
    third_s = {DATA_W{1'b0}};
    neg_s   = 1'b0;
    if (!mode_q) begin
      if (idx_q == 4'd0) begin
        pa_s  = elem_q[0];
        pb_s  = elem_q[3];
        neg_s = 1'b0;
      end else begin
        pa_s  = elem_q[1];
        pb_s  = elem_q[2];
        neg_s = 1'b1;
      end
    end else begin
      case (idx_q)
        4'd0:    begin pa_s = elem_q[0]; pb_s = elem_q[4]; end
        4'd1:    begin pa_s = elem_q[1]; pb_s = elem_q[5]; end
        4'd2:    begin pa_s = elem_q[2]; pb_s = elem_q[3]; end
        4'd3:    begin pa_s = elem_q[2]; pb_s = elem_q[4]; end
        4'd4:    begin pa_s = elem_q[1]; pb_s = elem_q[3]; end
        4'd5:    begin pa_s = elem_q[0]; pb_s = elem_q[5]; end
        default: begin pa_s = elem_q[0]; pb_s = elem_q[4]; end
      endcase
      case (idx_q)
        4'd1:    third_s = elem_q[8];
        4'd2:    third_s = elem_q[6];
        4'd3:    third_s = elem_q[7];
        4'd4:    third_s = elem_q[6];
        4'd5:    third_s = elem_q[8];
        4'd6:    third_s = elem_q[7];
        default: third_s = {DATA_W{1'b0}};
      endcase
      neg_s = (idx_q >= 4'd4);
    end
    pair_s   = pa_s * pb_s;
    triple_s = pp_q * third_s;
    if (mode_q) begin
      mag_s = {{(OUT_W-TP_W){triple_s[TP_W-1]}}, triple_s};
    end else begin
      mag_s = {{(OUT_W-PP_W){pair_s[PP_W-1]}}, pair_s};
    end
    term_s = neg_s ? -mag_s : mag_s;
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    adr_d   = adr_q;
    idx_d   = idx_q;
    pp_d    = pp_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d  = mode_i;
          base_d  = start_adress_i;
          adr_d   = start_adress_i;
          idx_d   = 4'd0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (last_load_s) begin
          idx_d   = 4'd0;
          acc_d   = {OUT_W{1'b0}};
          adr_d   = base_q;
          state_d = S_COMPUTE;
        end else begin
          idx_d = idx_q + 4'd1;
          adr_d = base_q + ADDR_W'(idx_q + 4'd1);
        end
      end
      S_COMPUTE: begin
        pp_d = pair_s;
        if (last_step_s) begin
          out_d   = acc_q + term_s;
          state_d = S_DONE;
        end else begin
          acc_d = acc_q + term_s;
          idx_d = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Control and result registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      base_q  <= {ADDR_W{1'b0}};
      adr_q   <= {ADDR_W{1'b0}};
      idx_q   <= 4'd0;
      pp_q    <= {PP_W{1'b0}};
      acc_q   <= {OUT_W{1'b0}};
      out_q   <= {OUT_W{1'b0}};
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      adr_q   <= adr_d;
      idx_q   <= idx_d;
      pp_q    <= pp_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Matrix element capture while streaming from memory.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < 9; k++) begin
        elem_q[k] <= {DATA_W{1'b0}};
      end
    end else if (state_q == S_LOAD) begin
      elem_q[idx_q] <= data_in_i;
    end
  end

endmodule

// File: tb/tb_det_calculator_param.sv
// Scoreboard bench for det_calculator_param: directed matrices with hand-computed
// determinants; a negedge monitor pops expectations whenever done is seen.
module tb_det_calculator_param;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int OW = 3*DW+2;

  logic                 clk, rst_n, start, mode, done, busy;
  logic [AW-1:0]        sa, adr;
  logic [DW-1:0]        din;
  logic signed [OW-1:0] res;
  logic [DW-1:0]        mem [16];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int bc, dc0;

  typedef struct {
    logic signed [OW-1:0] val;
    int                   t0;
    int                   lat;
    string                name;
  } exp_t;
  exp_t sb[$];

  int m_ext[9]   = '{-128, -128, 127, -128, 0, 0, 0, 0, 0};
  int m_wrap[9]  = '{3, 2, 1, 4, 0, 0, 0, 0, 0};
  int m_basic[9] = '{6, 1, 1, 4, -2, 5, 2, 8, 7};
  int m_sing[9]  = '{2, 0, 1, 1, 3, 2, 1, 1, 1};

  assign din = mem[adr];

  det_calculator_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mode_i(mode),
    .start_adress_i(sa), .data_in_i(din), .adress_o(adr),
    .out_put_o(res), .done_o(done), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with out_put=%0d, expected no completion", res);
      end else begin
        e = sb.pop_front();
        check({e.name, "_value"}, res, e.val);
        check({e.name, "_latency"}, cyc - e.t0, e.lat);
      end
    end
  end

  task automatic load(input int base, input int n, input int v[9]);
    for (int k = 0; k < n; k++) mem[(base + k) % 16] = DW'(v[k]);
  endtask

  task automatic issue(input logic m, input int base, input logic signed [OW-1:0] val,
                       input string name);
    sb.push_back('{val, cyc, (m ? 17 : 7), name});
    start = 1'b1;
    mode  = m;
    sa    = AW'(base);
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    sa    = AW'(base + 5);
  endtask

  task automatic wait_idle(input string name, output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 60 && busy; k++) begin
      busy_cycles++;
      @(negedge clk);
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy still high after 60 cycles, expected idle", name);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; sa = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (2) @(negedge clk);
    check("reset_out_put", res, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_adress", adr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    load(0, 4, m_ext);
    issue(1'b0, 0, 26'sd32640, "ext2x2");
    wait_idle("ext2x2", bc);

    load(14, 4, m_wrap);
    issue(1'b0, 14, 26'sd10, "wrap2x2");
    for (int k = 0; k < 4; k++) begin
      check("wrap_adress", adr, (14 + k) % 16);
      @(negedge clk);
    end
    check("wrap_compute_adress_holds_base", adr, 14);
    wait_idle("wrap2x2", bc);

    load(0, 9, m_basic);
    issue(1'b1, 0, -26'sd306, "basic3x3");
    wait_idle("basic3x3", bc);
    check("basic_busy_cycles", bc, 17);

    load(7, 9, m_sing);
    dc0 = done_cnt;
    issue(1'b1, 7, 26'sd0, "singular3x3");
    wait_idle("singular3x3", bc);
    check("singular_done_pulses", done_cnt - dc0, 1);

    load(0, 9, m_basic);
    issue(1'b1, 0, -26'sd306, "ignore3x3");
    repeat (11) @(negedge clk);
    start = 1'b1; mode = 1'b0; sa = 4'd5;
    @(negedge clk);
    start = 1'b0;
    wait_idle("ignore3x3", bc);
    issue(1'b0, 0, 26'sd23, "b2b2x2");
    wait_idle("b2b2x2", bc);

    load(0, 9, m_basic);
    start = 1'b1; mode = 1'b1; sa = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dc0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("midreset_out_put", res, 0);
    check("midreset_busy", busy, 0);
    check("midreset_adress", adr, 0);
    check("midreset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midreset_no_done", done_cnt - dc0, 0);
    load(9, 4, m_wrap);
    issue(1'b0, 9, 26'sd10, "after_reset2x2");
    wait_idle("after_reset2x2", bc);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running at 100000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
